// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer averaging path.
// Also imported by the downstream LED thermometer stage.
package accel_pkg;

    localparam int ACCEL_W            = 16;
    localparam int DEFAULT_LOG2_DEPTH = 3;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } avg_state_t;

    typedef logic signed [ACCEL_W-1:0] accel_t;

endpackage

// File: rtl/accel_sample_ring.sv
// Register-based ring of the last 2^LOG2_DEPTH samples with synchronous clear.
// The entry about to be overwritten (the oldest) is presented combinationally.
module accel_sample_ring
    import accel_pkg::*;
#(
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr_en,
    input  logic signed [ACCEL_W-1:0]   i_wr_data,
    output logic signed [ACCEL_W-1:0]   o_oldest,
    output logic [LOG2_DEPTH-1:0]       o_wr_ptr
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    accel_t                r_buf [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;

    // Power-of-two depth lets the pointer wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_buf[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
        end
    end

    assign o_oldest = r_buf[r_wr_ptr];
    assign o_wr_ptr = r_wr_ptr;

endmodule

// File: rtl/accel_averager.sv
// Boxcar averager over the last 2^LOG2_DEPTH accelerometer samples.
// Define ACCEL_DEADBAND_EN to snap means with |mean| < DEADBAND to zero.
module accel_averager
    import accel_pkg::*;
#(
    parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
    parameter int DEADBAND   = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [ACCEL_W-1:0]   in_sample,
    output logic signed [ACCEL_W-1:0]   accel,
    output logic                        out_valid,
    output logic                        primed
);

    localparam int                    DEPTH    = 1 << LOG2_DEPTH;
    localparam int                    SUM_W    = ACCEL_W + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] LAST_PTR = LOG2_DEPTH'(DEPTH - 1);

`ifdef ACCEL_DEADBAND_EN
    localparam bit DEADBAND_ON = 1'b1;
`else
    localparam bit DEADBAND_ON = 1'b0;
`endif

    avg_state_t              r_state;
    logic signed [SUM_W-1:0] r_sum;

    accel_t                  w_oldest;
    logic [LOG2_DEPTH-1:0]   w_wr_ptr;
    logic signed [SUM_W-1:0] w_sample_ext;
    logic signed [SUM_W-1:0] w_oldest_ext;
    logic signed [SUM_W-1:0] w_sum_next;
    accel_t                  w_mean;
    logic                    w_in_deadband;
    accel_t                  w_accel_next;

    accel_sample_ring #(
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (in_valid),
        .i_wr_data (in_sample),
        .o_oldest  (w_oldest),
        .o_wr_ptr  (w_wr_ptr)
    );

    assign w_sample_ext = {{LOG2_DEPTH{in_sample[ACCEL_W-1]}}, in_sample};
    assign w_oldest_ext = {{LOG2_DEPTH{w_oldest[ACCEL_W-1]}}, w_oldest};
    assign w_sum_next   = r_sum + w_sample_ext - w_oldest_ext;

    // Taking the top ACCEL_W bits is the arithmetic shift (floor division).
    assign w_mean = w_sum_next[LOG2_DEPTH +: ACCEL_W];

    assign w_in_deadband = (int'(w_mean) > -DEADBAND) && (int'(w_mean) < DEADBAND);
    assign w_accel_next  = (DEADBAND_ON && w_in_deadband) ? '0 : w_mean;

    // FILL ends on the accepted sample that wraps the ring pointer for the first time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FILL;
            r_sum     <= '0;
            accel     <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r_sum <= w_sum_next;
                accel <= w_accel_next;
                case (r_state)
                    FILL: begin
                        if (w_wr_ptr == LAST_PTR) begin
                            r_state <= RUN;
                            primed  <= 1'b1;
                        end
                    end
                    RUN: begin
                        r_state <= RUN;
                    end
                    default: begin
                        r_state <= FILL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_averager.sv
// Directed self-checking bench for accel_averager (LOG2_DEPTH = 3).
// Deadband expectations follow whether ACCEL_DEADBAND_EN is defined.
module tb_accel_averager;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic signed [15:0] accel;
    logic               out_valid;
    logic               primed;

    int compareCount  = 0;
    int mismatchCount = 0;

    accel_averager #(
        .LOG2_DEPTH (3),
        .DEADBAND   (512)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .accel     (accel),
        .out_valid (out_valid),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then samples just after the rising edge.
    task automatic applyStimulus(input logic valid, input int sample);
        in_valid  = valid;
        in_sample = 16'(sample);
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fillWith(input int sample, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b1, sample);
        end
    endtask

    int expMean;
    int dbExp400;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;

        // Reset held with a valid sample present must discard it.
        in_valid  = 1'b1;
        in_sample = 16'sd1000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_accel", int'(accel), 0);
            checkOutput("rst_out_valid", int'(out_valid), 0);
            checkOutput("rst_primed", int'(primed), 0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 0);
        checkOutput("post_rst_accel", int'(accel), 0);
        checkOutput("post_rst_out_valid", int'(out_valid), 0);
        checkOutput("post_rst_primed", int'(primed), 0);

        // Fill ramp: empty slots count as zero.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 8000);
            checkOutput($sformatf("fill_accel_%0d", i), int'(accel), 1000 * i);
            checkOutput($sformatf("fill_out_valid_%0d", i), int'(out_valid), 1);
            checkOutput($sformatf("fill_primed_%0d", i), int'(primed), (i == 8) ? 1 : 0);
        end

        // Idle cycle holds the value and does not strobe.
        applyStimulus(1'b0, 1234);
        checkOutput("idle_accel", int'(accel), 8000);
        checkOutput("idle_out_valid", int'(out_valid), 0);
        checkOutput("idle_primed", int'(primed), 1);

        // Wrap: -8000 replaces the oldest 8000.
        applyStimulus(1'b1, -8000);
        checkOutput("wrap_first", int'(accel), 6000);
        for (int j = 1; j <= 8; j++) begin
            applyStimulus(1'b1, -8000);
            expMean = (j < 8) ? (6000 - 2000 * j) : -8000;
            checkOutput($sformatf("wrap_accel_%0d", j), int'(accel), expMean);
        end
        checkOutput("wrap_primed", int'(primed), 1);

        // Rounding toward negative infinity.
        resetDut();
        applyStimulus(1'b1, -1);
        checkOutput("round_neg1", int'(accel), -1);
        checkOutput("round_primed", int'(primed), 0);

        resetDut();
        fillWith(-32768, 8);
        checkOutput("extreme_min", int'(accel), -32768);

        resetDut();
        fillWith(32767, 8);
        checkOutput("extreme_max", int'(accel), 32767);

        // Mid-run reset with a competing valid sample.
        resetDut();
        fillWith(4000, 5);
        checkOutput("midrun_pre", int'(accel), 2500);
        rst = 1'b1;
        applyStimulus(1'b1, 9999);
        checkOutput("midrun_rst_accel", int'(accel), 0);
        checkOutput("midrun_rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        applyStimulus(1'b1, 800);
        checkOutput("midrun_accel", int'(accel), 100);
        checkOutput("midrun_primed", int'(primed), 0);

`ifdef ACCEL_DEADBAND_EN
        dbExp400 = 0;
`else
        dbExp400 = 400;
`endif
        resetDut();
        fillWith(400, 8);
        checkOutput("deadband_400", int'(accel), dbExp400);
        resetDut();
        fillWith(512, 8);
        checkOutput("deadband_512", int'(accel), 512);
        resetDut();
        fillWith(-600, 8);
        checkOutput("deadband_neg600", int'(accel), -600);
        checkOutput("deadband_primed", int'(primed), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
